// File: rtl/lpif_dstrm_sched_pkg.sv
// Shared types and constants for the LPIF downstream scheduler.
package lpif_sched_pkg;

  localparam int unsigned SLOTS    = 4;
  localparam int unsigned SLOT_DW  = 128;
  localparam int unsigned SLOT_CW  = 8;
  localparam int unsigned PROTID_W = 2;

  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DRAIN   = 2'd3
  } sched_state_e;

  // Number of occupied flit slots in a 4-slot valid mask.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lpif_dstrm_sched_rr_arb.sv
// Round-robin arbiter: first eligible requester at or after the pointer wins.
module lpif_rr_arb
  import lpif_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_REQ-1:0]  i_elig,
  input  logic                i_upd_en,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [PROTID_W-1:0] o_winner
);

  logic [PROTID_W-1:0] r_ptr;
  logic                w_found;

  // Two passes: indices >= pointer first, then wrap to the low indices.
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_elig[i] && (i >= 32'(r_ptr))) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_winner   = PROTID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_elig[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_winner   = PROTID_W'(i);
      end
    end
  end

  // Pointer advances past the winner only when a grant is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_upd_en) begin
      if (o_winner == PROTID_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                                    r_ptr <= o_winner + 1'b1;
    end
  end

endmodule

// File: rtl/lpif_dstrm_sched.sv
// Downstream scheduler and credit controller in front of the LPIF datapath.
module lpif_dstrm_sched
  import lpif_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                            clk_wr,
  input  logic                            rst_wr_n,
  input  logic                            tx_online,
  input  logic [CREDIT_W-1:0]             init_downstream_credit,
  input  logic [2:0]                      credit_return,
  input  logic [3:0]                      lp_state,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*SLOTS-1:0]        req_dvalid,
  input  logic [NUM_REQ*SLOTS*SLOT_DW-1:0] req_data,
  input  logic [NUM_REQ*SLOTS*SLOT_CW-1:0] req_crc,
  input  logic [NUM_REQ*SLOTS-1:0]        req_crc_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [4*SLOTS-1:0]              dstrm_state,
  output logic [PROTID_W*SLOTS-1:0]       dstrm_protid,
  output logic [SLOTS*SLOT_DW-1:0]        dstrm_data,
  output logic [SLOTS-1:0]                dstrm_dvalid,
  output logic [SLOTS*SLOT_CW-1:0]        dstrm_crc,
  output logic [SLOTS-1:0]                dstrm_crc_valid,
  output logic [SLOTS-1:0]                dstrm_valid,
  output logic [CREDIT_W-1:0]             credit_avail,
  output logic [31:0]                     sched_debug_status
);

  sched_state_e r_state, w_state_nxt;

  logic [NUM_REQ-1:0]         w_elig, w_grant;
  logic [PROTID_W-1:0]        w_winner;
  logic                       w_any_grant, w_zero_dv;
  logic [SLOTS-1:0]           w_dv_i;
  logic [SLOTS-1:0]           w_win_dv, w_win_cv;
  logic [SLOTS*SLOT_DW-1:0]   w_win_data;
  logic [SLOTS*SLOT_CW-1:0]   w_win_crc;
  logic [PROTID_W*SLOTS-1:0]  w_protid;

  logic [2:0]                 w_ret_beats, w_used;
  logic [CREDIT_W+1:0]        w_credit_sum;
  logic                       w_ovf, w_ovf_set;
  logic [CREDIT_W-1:0]        r_credit, w_credit_nxt;

  logic                       r_cr_ovf, r_zero_dv;
  logic [PROTID_W-1:0]        r_last_win;
  logic [15:0]                r_gnt_cnt;

  logic [4*SLOTS-1:0]         r_dstrm_state;
  logic [PROTID_W*SLOTS-1:0]  r_protid;
  logic [SLOTS*SLOT_DW-1:0]   r_data;
  logic [SLOTS-1:0]           r_dvalid, r_crc_valid;
  logic [SLOTS*SLOT_CW-1:0]   r_crc;

  // Per-requester eligibility; reset suppresses any same-cycle handshake.
  always_comb begin
    w_elig    = '0;
    w_zero_dv = 1'b0;
    w_dv_i    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dv_i = req_dvalid[i*SLOTS +: SLOTS];
      if (req_valid[i] && (w_dv_i != '0) &&
          (CREDIT_W'(popcount4(w_dv_i)) <= r_credit) &&
          (r_state == ST_ACTIVE) && rst_wr_n)
        w_elig[i] = 1'b1;
      if (req_valid[i] && (w_dv_i == '0))
        w_zero_dv = 1'b1;
    end
  end

  lpif_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk    (clk_wr),
    .i_rst_n  (rst_wr_n),
    .i_elig   (w_elig),
    .i_upd_en (w_any_grant),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign w_any_grant = |w_grant;
  assign req_ready   = w_grant;

  // Select the granted requester's slices and build per-slot protocol ids.
  always_comb begin
    w_win_dv   = '0;
    w_win_cv   = '0;
    w_win_data = '0;
    w_win_crc  = '0;
    w_protid   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_dv   = req_dvalid[i*SLOTS +: SLOTS];
        w_win_cv   = req_crc_valid[i*SLOTS +: SLOTS];
        w_win_data = req_data[i*SLOTS*SLOT_DW +: SLOTS*SLOT_DW];
        w_win_crc  = req_crc[i*SLOTS*SLOT_CW +: SLOTS*SLOT_CW];
      end
    end
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (w_win_dv[k]) w_protid[k*PROTID_W +: PROTID_W] = w_winner;
    end
  end

  // Link state machine; tx_online re-assertion in DRAIN beats the OFFLINE exit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFFLINE: if (tx_online) w_state_nxt = ST_LOAD;
      ST_LOAD:    w_state_nxt = tx_online ? ST_ACTIVE : ST_OFFLINE;
      ST_ACTIVE:  if (!tx_online) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (tx_online)                             w_state_nxt = ST_ACTIVE;
        else if (r_credit == init_downstream_credit) w_state_nxt = ST_OFFLINE;
      end
      default:    w_state_nxt = ST_OFFLINE;
    endcase
  end

  // Credit update: consume granted beats, add capped returns, saturate.
  always_comb begin
    w_ret_beats  = (credit_return > 3'd4) ? 3'd4 : credit_return;
    w_used       = w_any_grant ? popcount4(w_win_dv) : 3'd0;
    w_credit_sum = (CREDIT_W+2)'(r_credit) - (CREDIT_W+2)'(w_used)
                 + (CREDIT_W+2)'(w_ret_beats);
    w_ovf        = w_credit_sum > (CREDIT_W+2)'({CREDIT_W{1'b1}});
    w_ovf_set    = 1'b0;
    if ((r_state == ST_OFFLINE) || (w_state_nxt == ST_OFFLINE)) begin
      w_credit_nxt = '0;
    end else if (r_state == ST_LOAD) begin
      w_credit_nxt = init_downstream_credit;
    end else if (w_ovf) begin
      w_credit_nxt = '1;
      w_ovf_set    = 1'b1;
    end else begin
      w_credit_nxt = w_credit_sum[CREDIT_W-1:0];
    end
  end

  // State, credit, status and registered downstream outputs.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      r_state       <= ST_OFFLINE;
      r_credit      <= '0;
      r_cr_ovf      <= 1'b0;
      r_zero_dv     <= 1'b0;
      r_last_win    <= '0;
      r_gnt_cnt     <= '0;
      r_dstrm_state <= '0;
      r_protid      <= '0;
      r_data        <= '0;
      r_dvalid      <= '0;
      r_crc         <= '0;
      r_crc_valid   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_dstrm_state <= {SLOTS{lp_state}};
      if (w_ovf_set) r_cr_ovf  <= 1'b1;
      if (w_zero_dv) r_zero_dv <= 1'b1;
      if (w_any_grant) begin
        r_last_win  <= w_winner;
        r_gnt_cnt   <= r_gnt_cnt + 16'd1;
        r_protid    <= w_protid;
        r_data      <= w_win_data;
        r_dvalid    <= w_win_dv;
        r_crc       <= w_win_crc;
        r_crc_valid <= w_win_cv;
      end else begin
        r_protid    <= '0;
        r_data      <= '0;
        r_dvalid    <= '0;
        r_crc       <= '0;
        r_crc_valid <= '0;
      end
    end
  end

  assign dstrm_state        = r_dstrm_state;
  assign dstrm_protid       = r_protid;
  assign dstrm_data         = r_data;
  assign dstrm_dvalid       = r_dvalid;
  assign dstrm_valid        = r_dvalid;
  assign dstrm_crc          = r_crc;
  assign dstrm_crc_valid    = r_crc_valid;
  assign credit_avail       = r_credit;
  assign sched_debug_status = {r_state, r_last_win, 8'(r_credit),
                               r_cr_ovf, r_zero_dv, 2'b00, r_gnt_cnt};

endmodule

// File: tb/tb_lpif_dstrm_sched.sv
// Directed bench for lpif_dstrm_sched with a queue-based output scoreboard.
module tb_lpif_dstrm_sched;

  localparam int unsigned NR = 2;
  localparam logic [511:0] D0 = {16{32'h1111_0000}};
  localparam logic [511:0] D1 = {16{32'h2222_FFFF}};
  localparam logic [31:0]  C0 = 32'hC0C1_C2C3;
  localparam logic [31:0]  C1 = 32'hD0D1_D2D3;
  localparam logic [3:0]   CV0 = 4'hA;
  localparam logic [3:0]   CV1 = 4'h5;

  logic            clk_wr = 1'b0;
  logic            rst_wr_n;
  logic            tx_online;
  logic [7:0]      init_downstream_credit;
  logic [2:0]      credit_return;
  logic [3:0]      lp_state;
  logic [NR-1:0]   req_valid;
  logic [NR*4-1:0] req_dvalid;
  logic [NR*512-1:0] req_data;
  logic [NR*32-1:0]  req_crc;
  logic [NR*4-1:0]   req_crc_valid;
  logic [NR-1:0]   req_ready;
  logic [15:0]     dstrm_state;
  logic [7:0]      dstrm_protid;
  logic [511:0]    dstrm_data;
  logic [3:0]      dstrm_dvalid;
  logic [31:0]     dstrm_crc;
  logic [3:0]      dstrm_crc_valid;
  logic [3:0]      dstrm_valid;
  logic [7:0]      credit_avail;
  logic [31:0]     sched_debug_status;

  always #5 clk_wr = ~clk_wr;

  lpif_dstrm_sched #(
    .NUM_REQ  (NR),
    .CREDIT_W (8)
  ) dut (
    .clk_wr                 (clk_wr),
    .rst_wr_n               (rst_wr_n),
    .tx_online              (tx_online),
    .init_downstream_credit (init_downstream_credit),
    .credit_return          (credit_return),
    .lp_state               (lp_state),
    .req_valid              (req_valid),
    .req_dvalid             (req_dvalid),
    .req_data               (req_data),
    .req_crc                (req_crc),
    .req_crc_valid          (req_crc_valid),
    .req_ready              (req_ready),
    .dstrm_state            (dstrm_state),
    .dstrm_protid           (dstrm_protid),
    .dstrm_data             (dstrm_data),
    .dstrm_dvalid           (dstrm_dvalid),
    .dstrm_crc              (dstrm_crc),
    .dstrm_crc_valid        (dstrm_crc_valid),
    .dstrm_valid            (dstrm_valid),
    .credit_avail           (credit_avail),
    .sched_debug_status     (sched_debug_status)
  );

  typedef struct {
    logic [7:0]   protid;
    logic [3:0]   dv;
    logic [511:0] data;
    logic [31:0]  crc;
    logic [3:0]   cv;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [3:0] dv0, input logic [3:0] dv1);
    req_valid  = v;
    req_dvalid = {dv1, dv0};
  endtask

  // Expected transfer for requester idx sending slots dv.
  task automatic push_exp(input int idx, input logic [3:0] dv);
    exp_t e;
    e.protid = '0;
    for (int k = 0; k < 4; k++)
      if (dv[k]) e.protid[2*k +: 2] = 2'(idx);
    e.dv   = dv;
    e.data = (idx == 1) ? D1 : D0;
    e.crc  = (idx == 1) ? C1 : C0;
    e.cv   = (idx == 1) ? CV1 : CV0;
    q.push_back(e);
  endtask

  // Output monitor: every valid downstream beat must match the oldest expectation.
  always @(negedge clk_wr) begin
    if (mon_en && (dstrm_valid !== 4'h0)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got valid=%h protid=%h, expected no output", dstrm_valid, dstrm_protid);
      end else begin
        m_e = q.pop_front();
        if (dstrm_protid !== m_e.protid || dstrm_dvalid !== m_e.dv || dstrm_valid !== m_e.dv ||
            dstrm_crc !== m_e.crc || dstrm_crc_valid !== m_e.cv || dstrm_data !== m_e.data) begin
          n_fail++;
          $display("FAIL out_txn: got protid=%h dv=%h valid=%h crc=%h cv=%h data=%h expected protid=%h dv=%h crc=%h cv=%h data=%h",
                   dstrm_protid, dstrm_dvalid, dstrm_valid, dstrm_crc, dstrm_crc_valid, dstrm_data,
                   m_e.protid, m_e.dv, m_e.crc, m_e.cv, m_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_wr_n = 1'b0;
    tx_online = 1'b0;
    init_downstream_credit = 8'd8;
    credit_return = 3'd0;
    lp_state = 4'h3;
    req_data = {D1, D0};
    req_crc = {C1, C0};
    req_crc_valid = {CV1, CV0};
    set_req(2'b00, 4'h0, 4'h0);
    tick();
    tick();
    mon_en = 1'b1;

    // Reset state
    chk("rst_credit", credit_avail, 0);
    chk("rst_status", sched_debug_status, 0);
    chk("rst_dstrm_state", dstrm_state, 0);
    chk("rst_valid", dstrm_valid, 0);

    // Bring-up
    rst_wr_n = 1'b1;
    tick();
    chk("dstrm_state", dstrm_state, 16'h3333);
    chk("fsm_offline", sched_debug_status[31:30], 0);
    tx_online = 1'b1;
    set_req(2'b01, 4'hF, 4'h0);
    #1;
    chk("offline_no_ready", req_ready, 0);
    tick();
    chk("fsm_load", sched_debug_status[31:30], 1);
    chk("load_no_ready", req_ready, 0);
    chk("load_credit", credit_avail, 0);
    set_req(2'b00, 4'h0, 4'h0);
    tick();
    chk("fsm_active", sched_debug_status[31:30], 2);
    chk("active_credit", credit_avail, 8);

    // Round-robin with full flit groups
    set_req(2'b11, 4'hF, 4'hF);
    #1;
    chk("rr_ready0", req_ready, 2'b01);
    push_exp(0, 4'hF);
    tick();
    chk("rr_credit4", credit_avail, 4);
    chk("rr_ready1", req_ready, 2'b10);
    push_exp(1, 4'hF);
    tick();
    chk("rr_credit0", credit_avail, 0);
    chk("rr_no_ready", req_ready, 0);
    tick();
    chk("rr_no_out", dstrm_valid, 0);

    // Credit limit skips the larger request
    set_req(2'b00, 4'h0, 4'h0);
    credit_return = 3'd2;
    tick();
    credit_return = 3'd0;
    chk("cl_credit2", credit_avail, 2);
    set_req(2'b11, 4'h7, 4'h3);
    #1;
    chk("cl_ready", req_ready, 2'b10);
    push_exp(1, 4'h3);
    tick();
    set_req(2'b00, 4'h0, 4'h0);
    chk("cl_credit0", credit_avail, 0);

    // Grant and return in the same cycle
    credit_return = 3'd4;
    tick();
    credit_return = 3'd0;
    chk("gr_credit4", credit_avail, 4);
    set_req(2'b01, 4'hF, 4'h0);
    credit_return = 3'd3;
    #1;
    chk("gr_ready", req_ready, 2'b01);
    push_exp(0, 4'hF);
    tick();
    set_req(2'b00, 4'h0, 4'h0);
    credit_return = 3'd0;
    chk("gr_credit3", credit_avail, 3);

    // Saturation at 255 (return value 7 behaves as 4)
    credit_return = 3'd7;
    repeat (62) tick();
    credit_return = 3'd3;
    tick();
    credit_return = 3'd0;
    chk("sat_credit254", credit_avail, 254);
    chk("sat_ovf0", sched_debug_status[19], 0);
    credit_return = 3'd4;
    tick();
    credit_return = 3'd0;
    chk("sat_credit255", credit_avail, 255);
    chk("sat_ovf1", sched_debug_status[19], 1);

    // Valid with no slots is never granted and is flagged
    set_req(2'b01, 4'h0, 4'h0);
    #1;
    chk("zdv_no_ready", req_ready, 0);
    tick();
    set_req(2'b00, 4'h0, 4'h0);
    chk("zdv_sticky", sched_debug_status[18], 1);

    // Reset while a transfer is in flight
    set_req(2'b11, 4'hF, 4'hF);
    #1;
    chk("mid_ready", req_ready, 2'b10);
    push_exp(1, 4'hF);
    tick();
    rst_wr_n = 1'b0;
    tick();
    chk("mid_rst_valid", dstrm_valid, 0);
    chk("mid_rst_data", dstrm_data[63:0], 0);
    chk("mid_rst_credit", credit_avail, 0);
    chk("mid_rst_status", sched_debug_status, 0);
    rst_wr_n = 1'b1;
    set_req(2'b00, 4'h0, 4'h0);
    tick();
    chk("re_load", sched_debug_status[31:30], 1);
    tick();
    chk("re_credit8", credit_avail, 8);

    // Drain back to offline once credit is fully returned
    set_req(2'b11, 4'h7, 4'hF);
    #1;
    chk("ptr_reset_ready", req_ready, 2'b01);
    push_exp(0, 4'h7);
    tick();
    chk("dr_credit5", credit_avail, 5);
    set_req(2'b00, 4'h0, 4'h0);
    tx_online = 1'b0;
    tick();
    chk("dr_fsm", sched_debug_status[31:30], 3);
    set_req(2'b11, 4'h1, 4'h1);
    #1;
    chk("dr_no_ready", req_ready, 0);
    credit_return = 3'd3;
    tick();
    credit_return = 3'd0;
    chk("dr_credit8", credit_avail, 8);
    chk("dr_fsm_hold", sched_debug_status[31:30], 3);
    set_req(2'b00, 4'h0, 4'h0);
    tick();
    chk("dr_offline", sched_debug_status[31:30], 0);
    chk("dr_credit0", credit_avail, 0);

    // Drain re-entered to ACTIVE when tx_online returns
    tx_online = 1'b1;
    tick();
    tick();
    chk("rea_credit8", credit_avail, 8);
    tx_online = 1'b0;
    tick();
    chk("rea_drain", sched_debug_status[31:30], 3);
    tx_online = 1'b1;
    tick();
    chk("rea_active", sched_debug_status[31:30], 2);
    set_req(2'b10, 4'h0, 4'hF);
    #1;
    chk("rea_ready", req_ready, 2'b10);
    push_exp(1, 4'hF);
    tick();
    set_req(2'b00, 4'h0, 4'h0);
    chk("rea_credit4", credit_avail, 4);
    chk("grant_count", sched_debug_status[15:0], 2);
    chk("last_winner", sched_debug_status[29:28], 1);
    tick();
    tick();
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lpif_dstrm_sched.md
Name: lpif_dstrm_sched

Overview:
- Downstream scheduler and credit controller sitting in front of an LPIF quarter-rate master datapath (4 flit slots/cycle, 512b data).
- Shares the dstrm_* channel between up to 4 protocol requesters using round-robin arbitration.
- Gates transmission on link online state and a downstream beat-credit budget.
- Drives dstrm_protid per slot with the granted requester index.

Parameters:
NUM_REQ, 2, number of requesters (legal 1..4)
CREDIT_W, 8, width of credit counter (matches init_downstream_credit)

Ports:
clk_wr  in  1  clock; single clock domain
rst_wr_n  in  1  reset; synchronous, active-low
tx_online  in  1  delayed TX online from auto-sync
init_downstream_credit  in  8  credit budget, loaded on going online
credit_return  in  3  beats returned this cycle (0..4; values 5..7 treated as 4)
lp_state  in  4  LPIF state, replicated per slot
req_valid  in  NUM_REQ  requester offers a flit group
req_dvalid  in  NUM_REQ*4  per-slot valid of each requester
req_data  in  NUM_REQ*512  per-requester 4x128b data
req_crc  in  NUM_REQ*32  per-requester 4x8b crc
req_crc_valid  in  NUM_REQ*4  per-slot crc valid
req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle
dstrm_state  out  16  {4{lp_state}} registered
dstrm_protid  out  8  2b requester index per slot
dstrm_data  out  512  granted data
dstrm_dvalid  out  4  granted dvalid
dstrm_crc  out  32  granted crc
dstrm_crc_valid  out  4  granted crc_valid
dstrm_valid  out  4  equals dstrm_dvalid
credit_avail  out  8  current credit count
sched_debug_status  out  32  status word

Behaviour:
- Reset (rst_wr_n=0 at clk_wr edge):
  - All outputs 0; FSM=OFFLINE; credit=0; rr pointer=0.
  - Sticky bits and grant count cleared.
- FSM:
  - OFFLINE: credit=0, no grants. tx_online=1 -> LOAD.
  - LOAD (1 cycle): credit<=init_downstream_credit, no grants -> ACTIVE. If tx_online=0 in LOAD -> OFFLINE.
  - ACTIVE: grants allowed. tx_online=0 -> DRAIN.
  - DRAIN: no grants; credit_return still accumulates.
    - credit==init_downstream_credit -> OFFLINE.
    - tx_online=1 -> ACTIVE. This takes priority over the OFFLINE exit.
- Eligibility:
  - Requester i is eligible when req_valid[i]=1, req_dvalid slice !=0, popcount(dvalid slice)<=credit, and FSM=ACTIVE.
  - req_valid=1 with dvalid=0 is never eligible and sets sticky bit zero_dv_err.
- Arbitration:
  - Round-robin starting at pointer; first eligible requester wins.
  - req_ready[winner]=1 in the same cycle. Transfer occurs when req_valid & req_ready.
  - Pointer<=winner+1 mod NUM_REQ only on a grant; otherwise held.
- Output:
  - Registered, 1-cycle latency from grant.
  - In a granted cycle, next-cycle outputs are set as follows:
    - dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid = the winner's slices.
    - dstrm_valid = dvalid.
    - dstrm_protid slot k = winner index if dvalid[k], else 0.
  - In a cycle with no grant, all dstrm_* except dstrm_state are 0 next cycle.
- Credit:
  - credit_next = credit - popcount(granted dvalid) + min(credit_return,4).
  - Computed at CREDIT_W+2 bits.
  - Saturates at 255; saturation sets sticky bit cr_ovf.
  - Grant and return in the same cycle are both applied.
  - credit_return is also applied in OFFLINE only if FSM is not OFFLINE (OFFLINE forces 0).
- sched_debug_status:
  - [31:30] FSM state; [29:28] last winner; [27:20] credit.
  - [19] cr_ovf; [18] zero_dv_err; [17:16] 0.
  - [15:0] wrapping count of grants.
- Reset mid-operation: reset dominates all inputs; in-flight registered output is cleared next edge.

Decomposition:
- Package lpif_sched_pkg:
  - State enum {OFFLINE=0, LOAD=1, ACTIVE=2, DRAIN=3}.
  - Constants SLOTS=4, SLOT_DW=128, SLOT_CW=8, PROTID_W=2.
  - popcount4 function.
- Sub-module lpif_rr_arb:
  - Parameterised NUM_REQ round-robin arbiter.
  - Inputs: eligible vector and pointer update enable.
  - Outputs: one-hot grant and winner index.

Test Plan:
- Bring-up: reset, init_downstream_credit=8, tx_online 0->1 -> FSM LOAD then ACTIVE, credit_avail=8, no grant during LOAD.
- Round-robin: both requesters valid with dvalid=4'hF, credit=8, return=0 -> grants req0 then req1, dstrm_protid=8'h00 then 8'h55, credit 8->4->0, third cycle no grant.
- Credit limit: credit=2, req0 dvalid=4'h7, req1 dvalid=4'h3 -> req0 skipped, req1 granted, dstrm_dvalid=4'h3, protid=8'h05, credit=0.
- Simultaneous grant+return: credit=4, grant 4 beats, credit_return=3 in same cycle -> credit=3; credit=254 with return=4 and no grant -> credit=255, cr_ovf=1.
- Drain: ACTIVE with credit=5, init=8, tx_online->0 -> DRAIN, no req_ready; return 3 -> OFFLINE, credit=0. Repeat with tx_online reasserted in DRAIN -> ACTIVE.
- Reset mid-traffic: rst_wr_n low during grant cycle -> all outputs 0 next edge, FSM OFFLINE, pointer 0.
